tagfifo_mp: RTL and testbench

- Multi-ported free-tag list for the rename/dispatch stage. Parametrised successor of the single-port tag FIFO.
- Dispatch pops up to N_RD free tags per cycle. The CDB returns up to N_WR retired tags per cycle.
- Reports occupancy and sticky protocol-error flags.
- Resets FULL, holding tags 0..N_ENTRY-1 in order.

---
 rtl/tagfifo_mp.sv | 174 +++++++++++++++++
 tb/tb_tagfifo_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tagfifo_mp.sv
// Multi-ported free-tag list: N_RD in-order pops and N_WR compacted pushes per cycle.
// Optional duplicate-tag filtering with TAGFIFO_MP_DUPCHK_EN (needs W_DATA == W_ADDR).
module tagfifo_mp #(
    parameter int W_DATA = 6,
    parameter int W_ADDR = 6,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_RD-1:0]          dispatch_ren,
    output logic [N_RD*W_DATA-1:0]   dispatch_tag,
    output logic [N_RD-1:0]          dispatch_avail,
    output logic                     dispatch_empty,
    output logic                     dispatch_full,
    input  logic [N_WR-1:0]          cdb_valid,
    input  logic [N_WR*W_DATA-1:0]   cdb_tag,
    output logic [W_ADDR:0]          count,
    output logic                     err_ovf,
    output logic                     err_ren
`ifdef TAGFIFO_MP_DUPCHK_EN
    ,
    output logic                     err_dup
`endif
);

    localparam int N_ENTRY = 2 ** W_ADDR;
    localparam int CW      = W_ADDR + 2;
    localparam logic [CW-1:0] N_ENTRY_C = CW'(N_ENTRY);

    logic [W_DATA-1:0] mem_q [N_ENTRY];
    logic [W_ADDR:0]   rptr_q, rptr_d, wptr_q, wptr_d, count_q, count_d;
    logic              err_ovf_q, err_ovf_d, err_ren_q, err_ren_d;
    logic [W_ADDR-1:0] rd_addr_s [N_RD];
    logic [W_ADDR-1:0] wr_addr_s [N_WR];
    logic [N_RD-1:0]   grant_s;
    logic [N_WR-1:0]   wr_en_s, dup_hit_s;
    logic [CW-1:0]     pops_s, acc_s, space_s, push_k_s;
    logic              pop_contig_s, ovf_s;

    // Read-side view: everything derives from registered state only
    always_comb begin
        dispatch_tag = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_addr_s[i] = rptr_q[W_ADDR-1:0] + W_ADDR'(i);
            dispatch_tag[i*W_DATA +: W_DATA] = mem_q[rd_addr_s[i]];
            dispatch_avail[i] = (CW'(count_q) > CW'(i));
        end
        dispatch_empty = (count_q == '0);
        dispatch_full  = (CW'(count_q) == N_ENTRY_C);
    end

    // Pop grant: contiguous prefix of requests limited to available ports
    always_comb begin
        grant_s      = '0;
        pops_s       = '0;
        pop_contig_s = 1'b1;
        for (int i = 0; i < N_RD; i++) begin
            if (dispatch_ren[i] && pop_contig_s && dispatch_avail[i]) begin
                grant_s[i] = 1'b1;
                pops_s     = pops_s + CW'(1);
            end else begin
                pop_contig_s = 1'b0;
            end
        end
    end

    // Push compaction; space freed by this cycle's pops is usable immediately
    always_comb begin
        space_s  = (N_ENTRY_C - CW'(count_q)) + pops_s;
        push_k_s = '0;
        acc_s    = '0;
        ovf_s    = 1'b0;
        wr_en_s  = '0;
        for (int j = 0; j < N_WR; j++) begin
            wr_addr_s[j] = '0;
            if (cdb_valid[j] && !dup_hit_s[j]) begin
                if (push_k_s < space_s) begin
                    wr_en_s[j]   = 1'b1;
                    wr_addr_s[j] = wptr_q[W_ADDR-1:0] + push_k_s[W_ADDR-1:0];
                    acc_s        = acc_s + CW'(1);
                end else begin
                    ovf_s = 1'b1;
                end
                push_k_s = push_k_s + CW'(1);
            end else begin
                wr_en_s[j] = 1'b0;
            end
        end
    end

    // Next-state for pointers, occupancy and sticky errors
    always_comb begin
        rptr_d    = rptr_q + pops_s[W_ADDR:0];
        wptr_d    = wptr_q + acc_s[W_ADDR:0];
        count_d   = count_q + acc_s[W_ADDR:0] - pops_s[W_ADDR:0];
        err_ovf_d = err_ovf_q | ovf_s;
        err_ren_d = err_ren_q | (|(dispatch_ren & ~grant_s));
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr_q    <= '0;
            wptr_q    <= (W_ADDR+1)'(N_ENTRY);
            count_q   <= (W_ADDR+1)'(N_ENTRY);
            err_ovf_q <= 1'b0;
            err_ren_q <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_ren_q <= err_ren_d;
        end
    end

    // Tag storage, reset to the identity list 0..N_ENTRY-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ENTRY; i++) mem_q[i] <= W_DATA'(i);
        end else begin
            for (int j = 0; j < N_WR; j++) begin
                if (wr_en_s[j]) mem_q[wr_addr_s[j]] <= cdb_tag[j*W_DATA +: W_DATA];
            end
        end
    end

`ifdef TAGFIFO_MP_DUPCHK_EN
    logic [N_ENTRY-1:0] free_q, free_d;
    logic               err_dup_q, err_dup_d;

    // Duplicate detection against the registered free map and earlier ports
    always_comb begin
        for (int j = 0; j < N_WR; j++) begin
            dup_hit_s[j] = free_q[cdb_tag[j*W_DATA +: W_ADDR]];
            for (int e = 0; e < j; e++) begin
                dup_hit_s[j] = dup_hit_s[j] | (cdb_valid[e] &&
                    (cdb_tag[e*W_DATA +: W_DATA] == cdb_tag[j*W_DATA +: W_DATA]));
            end
        end
        free_d = free_q;
        for (int i = 0; i < N_RD; i++) begin
            free_d[dispatch_tag[i*W_DATA +: W_ADDR]] =
                free_d[dispatch_tag[i*W_DATA +: W_ADDR]] & ~grant_s[i];
        end
        for (int j = 0; j < N_WR; j++) begin
            free_d[cdb_tag[j*W_DATA +: W_ADDR]] =
                free_d[cdb_tag[j*W_DATA +: W_ADDR]] | wr_en_s[j];
        end
        err_dup_d = err_dup_q | (|(cdb_valid & dup_hit_s));
    end

    // Free map and duplicate error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_q    <= '1;
            err_dup_q <= 1'b0;
        end else begin
            free_q    <= free_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign err_dup = err_dup_q;
`else
    assign dup_hit_s = '0;
`endif

    assign count   = count_q;
    assign err_ovf = err_ovf_q;
    assign err_ren = err_ren_q;

endmodule

// File: tb/tb_tagfifo_mp.sv
// Randomized bench for tagfifo_mp against a queue-based free-list model.
module tb_tagfifo_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  dispatch_ren;
    logic [11:0] dispatch_tag;
    logic [1:0]  dispatch_avail;
    logic        dispatch_empty, dispatch_full;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [6:0]  count;
    logic        err_ovf, err_ren;
`ifdef TAGFIFO_MP_DUPCHK_EN
    logic        err_dup;
`endif

    int n_vec = 0;
    int n_err = 0;
    int q[$];
    bit m_ovf, m_ren, m_dup;

    tagfifo_mp #(.W_DATA(6), .W_ADDR(6), .N_RD(2), .N_WR(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .dispatch_ren(dispatch_ren), .dispatch_tag(dispatch_tag),
        .dispatch_avail(dispatch_avail), .dispatch_empty(dispatch_empty),
        .dispatch_full(dispatch_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .count(count), .err_ovf(err_ovf), .err_ren(err_ren)
`ifdef TAGFIFO_MP_DUPCHK_EN
        , .err_dup(err_dup)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(i);
        m_ovf = 1'b0; m_ren = 1'b0; m_dup = 1'b0;
    endtask

    function automatic bit in_list(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of list semantics: grant pops, then compacted pushes into remaining room
    task automatic model_step(input logic [1:0] r, input logic [1:0] v, input int t0, input int t1);
        int n, pops, space, k;
        bit contig;
        bit dup [2];
        int t [2];
        t[0] = t0; t[1] = t1;
        n = q.size(); pops = 0; contig = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (r[i] && contig && i < n) pops++;
            else begin
                contig = 1'b0;
                if (r[i]) m_ren = 1'b1;
            end
        end
        dup[0] = 1'b0; dup[1] = 1'b0;
`ifdef TAGFIFO_MP_DUPCHK_EN
        dup[0] = in_list(t0);
        dup[1] = in_list(t1) || (v[0] && t0 == t1);
`endif
        space = 64 - n + pops;
        for (int i = 0; i < pops; i++) void'(q.pop_front());
        k = 0;
        for (int j = 0; j < 2; j++) begin
            if (v[j]) begin
                if (dup[j]) m_dup = 1'b1;
                else begin
                    if (k < space) q.push_back(t[j]);
                    else m_ovf = 1'b1;
                    k++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(dispatch_empty), 32'(q.size() == 0));
        chk("full", 32'(dispatch_full), 32'(q.size() == 64));
        for (int i = 0; i < 2; i++) begin
            chk("avail", 32'(dispatch_avail[i]), 32'(q.size() > i));
            if (q.size() > i) chk("tag", 32'(dispatch_tag[i*6 +: 6]), 32'(q[i]));
        end
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("err_ren", 32'(err_ren), 32'(m_ren));
`ifdef TAGFIFO_MP_DUPCHK_EN
        chk("err_dup", 32'(err_dup), 32'(m_dup));
`endif
    endtask

    // Called at a negedge; returns at the following negedge after checking
    task automatic step(input logic [1:0] r, input logic [1:0] v, input int t0, input int t1);
        dispatch_ren = r;
        cdb_valid    = v;
        cdb_tag      = {6'(t1), 6'(t0)};
        model_step(r, v, t0, t1);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset between edges, checked before any clock edge occurs
    task automatic do_reset();
        dispatch_ren = 2'b00; cdb_valid = 2'b00; cdb_tag = 12'd0;
        #1 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset_n = 1'b0;
        dispatch_ren = 2'b00; cdb_valid = 2'b00; cdb_tag = 12'd0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("t1_count", 32'(count), 32'd64);
        chk("t1_full", 32'(dispatch_full), 32'd1);
        chk("t1_tag0", 32'(dispatch_tag[5:0]), 32'd0);
        chk("t1_tag1", 32'(dispatch_tag[11:6]), 32'd1);
        chk("t1_avail", 32'(dispatch_avail), 32'd3);

        for (int i = 0; i < 32; i++) begin
            chk("t2_tag0", 32'(dispatch_tag[5:0]), 32'(2*i));
            chk("t2_tag1", 32'(dispatch_tag[11:6]), 32'(2*i+1));
            step(2'b11, 2'b00, 0, 0);
        end
        chk("t2_empty", 32'(dispatch_empty), 32'd1);
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_avail", 32'(dispatch_avail), 32'd0);
        chk("t2_errs", 32'({err_ovf, err_ren}), 32'd0);

        step(2'b00, 2'b10, 0, 9);
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_tag0", 32'(dispatch_tag[5:0]), 32'd9);
        chk("t3_avail", 32'(dispatch_avail), 32'd1);
        step(2'b11, 2'b00, 0, 0);
        chk("t3_count2", 32'(count), 32'd0);
        chk("t3_err_ren", 32'(err_ren), 32'd1);

        do_reset();
        step(2'b01, 2'b11, 40, 41);
        chk("t4_count", 32'(count), 32'd64);
        chk("t4_err_ovf", 32'(err_ovf), 32'd1);
        chk("t4_tag0", 32'(dispatch_tag[5:0]), 32'd1);

        do_reset();
        for (int i = 0; i < 32; i++) step(2'b11, 2'b00, 0, 0);
        for (int i = 0; i < 32; i++) step(2'b00, 2'b11, 63 - 2*i, 62 - 2*i);
        chk("t5_count", 32'(count), 32'd64);
        for (int i = 0; i < 32; i++) begin
            chk("t5_tag0", 32'(dispatch_tag[5:0]), 32'(63 - 2*i));
            chk("t5_tag1", 32'(dispatch_tag[11:6]), 32'(62 - 2*i));
            step(2'b11, 2'b00, 0, 0);
        end

        do_reset();
        step(2'b10, 2'b00, 0, 0);
        for (int i = 0; i < 23; i++) step(2'b11, 2'b00, 0, 0);
        step(2'b01, 2'b00, 0, 0);
        chk("t6_count17", 32'(count), 32'd17);
        do_reset();
        chk("t6_count", 32'(count), 32'd64);
        chk("t6_tag0", 32'(dispatch_tag[5:0]), 32'd0);
        chk("t6_errs", 32'({err_ovf, err_ren}), 32'd0);
`ifdef TAGFIFO_MP_DUPCHK_EN
        step(2'b11, 2'b00, 0, 0);
        step(2'b00, 2'b01, 5, 0);
        chk("t6_err_dup", 32'(err_dup), 32'd1);
        chk("t6_dup_count", 32'(count), 32'd62);
        do_reset();
`endif

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
